spu_mpy_pipe: RTL and testbench
===============================

Name: spu_mpy_pipe

Overview:
- Pipelined even-pipe fixed-point multiply execution stage for the SPU.
- Accepts issued multiply instructions (opcode, 128-bit RA/RB operands, 10-bit immediate, RT address).
- Computes the per-word-slot 16x16 product across all four 32-bit slots.
- Delivers result plus RT address to writeback after a fixed latency, with stall and flush control from the issue/control logic.

Parameters:
LATENCY, 7, clock edges from acceptance to result valid at outputs; legal range 2..15
ADDR_W, 7, RT register address width (128-entry register file)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction issued this cycle
in_op  input  3  opcode: 0 MPY, 1 MPYU, 2 MPYH, 3 MPYS, 4 MPYHH, 5 MPYHHU, 6 MPYI, 7 reserved
in_ra  input  128  operand RA
in_rb  input  128  operand RB (ignored for MPYI)
in_imm  input  10  signed immediate (MPYI only)
in_rt_addr  input  ADDR_W  destination register
stall  input  1  freeze entire pipeline
flush  input  1  kill all in-flight and same-cycle instructions
out_valid  output  1  result valid this cycle
out_rt_addr  output  ADDR_W  destination of result
out_result  output  128  result vector
busy  output  1  any stage holds a valid instruction

Behaviour:
- Slot i (i=0..3) occupies bits [32*i +: 32]. lo(X) = X[32*i +: 16]. hi(X) = X[32*i+16 +: 16].
- Per-slot result, 32 bits:
  - MPY: signed lo(RA) * signed lo(RB).
  - MPYU: unsigned lo(RA) * unsigned lo(RB).
  - MPYH: (hi(RA) * lo(RB)) << 16, truncated to 32 bits.
  - MPYS: (signed lo(RA) * signed lo(RB)) >>> 16, sign-extended to 32 bits.
  - MPYHH: signed hi(RA) * signed hi(RB).
  - MPYHHU: unsigned hi(RA) * unsigned hi(RB).
  - MPYI: signed lo(RA) * sext16(in_imm).
  - Opcode 7: result 0; still flows through the pipe and emerges valid.
- Arithmetic:
  - Product computed in stage 1.
  - Stages 2..LATENCY are pure delay registers carrying valid, rt_addr and result.
  - No overflow possible; all products fit in 32 bits.
- Acceptance:
  - in_valid is sampled at a rising edge where stall=0 and flush=0.
  - in_valid is ignored while stall=1; the issuer must hold or re-issue the instruction.
- Latency:
  - With no stall, an instruction accepted at edge k presents out_valid=1 with its result after edge k+LATENCY-1, i.e. exactly LATENCY edges including the acceptance edge.
  - Throughput is one instruction per cycle; results leave in issue order.
- Stall:
  - All stage registers hold.
  - out_valid, out_rt_addr and out_result hold their values for the duration of the stall; writeback ignores out_valid while stall=1.
  - Each stall cycle adds one cycle of latency to every in-flight instruction.
- Flush:
  - At the edge where flush=1, all stage valid bits clear and the same-cycle in_valid is discarded.
  - Flush takes priority over stall.
  - out_valid=0 and busy=0 from the following cycle.
- Outputs when out_valid=0: out_result and out_rt_addr are driven to 0.
- busy: combinational OR of all stage valid bits.
- Reset:
  - At the edge where rst=1, all valid bits, data registers and outputs go to 0.
  - Reset overrides flush, stall and in_valid, including mid-operation.
  - The first instruction can be accepted at the first edge with rst=0.

Test Plan:
- Reset mid-flow: issue 3 MPY, assert rst 1 cycle at cycle 3 -> out_valid=0, out_result=0, busy=0 from the next cycle; no result emerges.
- MPY vs MPYU: all slots lo(RA)=0xFFFE, lo(RB)=0x0003 -> MPY gives 0xFFFFFFFA in each slot, MPYU gives 0x0002FFFA. Each valid exactly 7 cycles after issue, with the correct rt_addr.
- MPYH/MPYS/MPYHH:
  - hi(RA)=0x0002, lo(RB)=0x0010, MPYH -> 0x00200000.
  - lo(RA)=0xFFFE, lo(RB)=0x0003, MPYS -> 0xFFFFFFFF.
  - hi(RA)=hi(RB)=0x8000, MPYHH -> 0x40000000; MPYHHU -> 0x40000000.
- MPYI: in_imm=0x3FF, lo(RA)=0x0005 -> 0xFFFFFFFB all slots. Opcode 7 -> valid with result 0.
- Back-to-back: 3 issues on consecutive cycles, stall 2 cycles starting at cycle 4 -> results in order at cycles 9, 10, 11; outputs held during stall; none lost or duplicated.
- Flush: 3 in flight, flush asserted together with in_valid and stall -> no out_valid ever for those 4 instructions; busy=0 next cycle; new issue afterwards emerges after 7 cycles.

Source files
------------

// File: rtl/spu_mpy_pipe_if.sv
// Issue/writeback bundle for the SPU even-pipe multiply stage.
// The issue/control side drives the instruction fields plus stall and flush.
// The multiply stage returns the result, its RT address and a busy flag.
interface spu_mpy_pipe_if #(
  parameter int ADDR_W = 7
);
  logic              in_valid;
  logic [2:0]        in_op;
  logic [127:0]      in_ra;
  logic [127:0]      in_rb;
  logic [9:0]        in_imm;
  logic [ADDR_W-1:0] in_rt_addr;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [ADDR_W-1:0] out_rt_addr;
  logic [127:0]      out_result;
  logic              busy;

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_imm, in_rt_addr, stall, flush,
    input  out_valid, out_rt_addr, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_imm, in_rt_addr, stall, flush,
    output out_valid, out_rt_addr, out_result, busy
  );
endinterface

// File: rtl/spu_mpy_pipe.sv
// SPU even-pipe fixed-point multiply stage.
// Stage 1 forms four independent 16x16 word-slot products.
// Stages 2..LATENCY only delay valid, RT address and result.
// Stall freezes every stage, and flush clears every valid bit.
// Reset clears both the control state and the data state.
module spu_mpy_pipe #(
  parameter int LATENCY = 7,
  parameter int ADDR_W  = 7
) (
  input logic            clk,
  input logic            rst,
  spu_mpy_pipe_if.slave  bus
);

  localparam logic [2:0] OP_MPY    = 3'd0;
  localparam logic [2:0] OP_MPYU   = 3'd1;
  localparam logic [2:0] OP_MPYH   = 3'd2;
  localparam logic [2:0] OP_MPYS   = 3'd3;
  localparam logic [2:0] OP_MPYHH  = 3'd4;
  localparam logic [2:0] OP_MPYHHU = 3'd5;
  localparam logic [2:0] OP_MPYI   = 3'd6;

  // Every operand is extended to 17 bits, so signed and unsigned forms share one multiplier.
  // The 32-bit product is exact for every opcode.
  function automatic logic [31:0] slot_product(
    input logic [2:0]  op,
    input logic [31:0] ra,
    input logic [31:0] rb,
    input logic [9:0]  imm
  );
    logic signed [16:0] a;
    logic signed [16:0] b;
    logic signed [31:0] p;
    logic        [31:0] r;
    a = '0;
    b = '0;
    case (op)
      OP_MPY:    begin a = {ra[15], ra[15:0]};   b = {rb[15], rb[15:0]};   end
      OP_MPYU:   begin a = {1'b0, ra[15:0]};     b = {1'b0, rb[15:0]};     end
      OP_MPYH:   begin a = {1'b0, ra[31:16]};    b = {1'b0, rb[15:0]};     end
      OP_MPYS:   begin a = {ra[15], ra[15:0]};   b = {rb[15], rb[15:0]};   end
      OP_MPYHH:  begin a = {ra[31], ra[31:16]};  b = {rb[31], rb[31:16]};  end
      OP_MPYHHU: begin a = {1'b0, ra[31:16]};    b = {1'b0, rb[31:16]};    end
      OP_MPYI:   begin a = {ra[15], ra[15:0]};   b = {{7{imm[9]}}, imm};   end
      default:   begin a = '0;                   b = '0;                   end
    endcase
    p = a * b;
    case (op)
      OP_MPYH: r = {p[15:0], 16'h0000};
      OP_MPYS: r = {{16{p[31]}}, p[31:16]};
      default: r = p;
    endcase
    return r;
  endfunction

  logic [127:0]      w_prod_p0;
  logic              w_busy;
  logic              r_vld_p [1:LATENCY];
  logic [ADDR_W-1:0] r_rt_p  [1:LATENCY];
  logic [127:0]      r_res_p [1:LATENCY];

  // Stage 0 -> 1: compute all four slot products from the issued operands.
  always_comb begin
    w_prod_p0 = '0;
    for (int s = 0; s < 4; s++) begin
      w_prod_p0[32*s +: 32] = slot_product(bus.in_op, bus.in_ra[32*s +: 32],
                                           bus.in_rb[32*s +: 32], bus.in_imm);
    end
  end

  // Pipeline advance: reset wins over flush, flush wins over stall, and stall holds every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= LATENCY; i++) begin
        r_vld_p[i] <= 1'b0;
        r_rt_p[i]  <= '0;
        r_res_p[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 1; i <= LATENCY; i++) begin
        r_vld_p[i] <= 1'b0;
      end
    end else if (!bus.stall) begin
      r_vld_p[1] <= bus.in_valid;
      r_rt_p[1]  <= bus.in_rt_addr;
      r_res_p[1] <= w_prod_p0;
      // Stages 2..LATENCY: pure delay of valid, RT address and result.
      for (int i = 2; i <= LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_rt_p[i]  <= r_rt_p[i-1];
        r_res_p[i] <= r_res_p[i-1];
      end
    end
  end

  // Busy flag: asserted while any stage holds a live instruction.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 1; i <= LATENCY; i++) begin
      w_busy = w_busy | r_vld_p[i];
    end
  end

  // Writeback outputs are forced to zero while there is no valid result.
  assign bus.out_valid   = r_vld_p[LATENCY];
  assign bus.out_rt_addr = r_vld_p[LATENCY] ? r_rt_p[LATENCY]  : '0;
  assign bus.out_result  = r_vld_p[LATENCY] ? r_res_p[LATENCY] : '0;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_spu_mpy_pipe.sv
// Testbench for spu_mpy_pipe.
// A reference model tracks each accepted instruction by its age in non-stalled edges.
// It predicts writeback from that age.
module tb_spu_mpy_pipe;
  localparam int LAT = 7;
  localparam int AW  = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spu_mpy_pipe_if #(.ADDR_W(AW)) bus();
  spu_mpy_pipe #(.LATENCY(LAT), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] rt;
    logic [127:0]  res;
    int            age;
  } item_t;

  item_t          q[$];
  logic           exp_valid;
  logic           exp_busy;
  logic [AW-1:0]  exp_rt;
  logic [127:0]   exp_res;
  logic [136:0]   obs;
  logic [136:0]   expv;

  // Slot arithmetic, written with plain integer arithmetic from the opcode definitions.
  function automatic logic [31:0] ref_slot(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [9:0] imm);
    longint las, lbs, has, hbs, lau, lbu, hau, hbu, im, p;
    las = longint'($signed(a[15:0]));  lbs = longint'($signed(b[15:0]));
    has = longint'($signed(a[31:16])); hbs = longint'($signed(b[31:16]));
    lau = longint'(a[15:0]);           lbu = longint'(b[15:0]);
    hau = longint'(a[31:16]);          hbu = longint'(b[31:16]);
    im  = longint'($signed(imm));
    case (op)
      3'd0:    p = las * lbs;
      3'd1:    p = lau * lbu;
      3'd2:    p = (hau * lbu) << 16;
      3'd3:    p = (las * lbs) >>> 16;
      3'd4:    p = has * hbs;
      3'd5:    p = hau * hbu;
      3'd6:    p = las * im;
      default: p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic logic [127:0] ref_vec(input logic [2:0] op, input logic [127:0] a,
                                           input logic [127:0] b, input logic [9:0] imm);
    logic [127:0] r;
    for (int s = 0; s < 4; s++) r[32*s +: 32] = ref_slot(op, a[32*s +: 32], b[32*s +: 32], imm);
    return r;
  endfunction

  // Reference model: age counts accepting/advancing edges; an item is visible at age LAT.
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      q.delete();
    end else if (!bus.stall) begin
      for (int i = 0; i < q.size(); i++) begin
        item_t t;
        t = q[i];
        t.age = t.age + 1;
        q[i] = t;
      end
      if (q.size() > 0 && q[0].age > LAT) void'(q.pop_front());
      if (bus.in_valid) begin
        item_t n;
        n.rt  = bus.in_rt_addr;
        n.res = ref_vec(bus.in_op, bus.in_ra, bus.in_rb, bus.in_imm);
        n.age = 1;
        q.push_back(n);
      end
    end
    exp_busy  = (q.size() > 0);
    exp_valid = (q.size() > 0) && (q[0].age == LAT);
    exp_rt    = exp_valid ? q[0].rt  : '0;
    exp_res   = exp_valid ? q[0].res : '0;
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [127:0] ra,
                       input logic [127:0] rb, input logic [9:0] imm, input logic [AW-1:0] rt,
                       input logic st, input logic fl, input logic r);
    bus.in_valid = v;  bus.in_op = op;   bus.in_ra = ra; bus.in_rb = rb;
    bus.in_imm = imm;  bus.in_rt_addr = rt;
    bus.stall = st;    bus.flush = fl;   rst = r;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    drive(1'b1, 3'd0, rnd128(), rnd128(), '0, 7'd3, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    obs = {bus.out_valid, bus.out_rt_addr, bus.out_result, bus.busy};
    total++;
    if (obs !== 137'b0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    idle();
  endtask

  task automatic test_directed();
    logic [31:0] va[8], vb[8], ve[8];
    logic [9:0]  vi[8];
    int n;
    va[0] = 32'h7777FFFE; vb[0] = 32'h55550003; vi[0] = 10'h000; ve[0] = 32'hFFFFFFFA;
    va[1] = 32'h7777FFFE; vb[1] = 32'h55550003; vi[1] = 10'h000; ve[1] = 32'h0002FFFA;
    va[2] = 32'h00029999; vb[2] = 32'h33330010; vi[2] = 10'h000; ve[2] = 32'h00200000;
    va[3] = 32'h1111FFFE; vb[3] = 32'h22220003; vi[3] = 10'h000; ve[3] = 32'hFFFFFFFF;
    va[4] = 32'h80001234; vb[4] = 32'h80005678; vi[4] = 10'h000; ve[4] = 32'h40000000;
    va[5] = 32'h80001234; vb[5] = 32'h80005678; vi[5] = 10'h000; ve[5] = 32'h40000000;
    va[6] = 32'h44440005; vb[6] = 32'hDEADBEEF; vi[6] = 10'h3FF; ve[6] = 32'hFFFFFFFB;
    va[7] = 32'h12345678; vb[7] = 32'h9ABCDEF0; vi[7] = 10'h155; ve[7] = 32'h00000000;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), {4{va[k]}}, {4{vb[k]}}, vi[k], AW'(20 + k), 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      n = 1;
      while (bus.out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (n !== LAT) begin
        bad++;
        $display("FAIL latency_op%0d: got %0d edges want %0d", k, n, LAT);
      end
      total++;
      if (bus.out_result !== {4{ve[k]}}) begin
        bad++;
        $display("FAIL result_op%0d: got %h want %h", k, bus.out_result, {4{ve[k]}});
      end
      total++;
      if (bus.out_rt_addr !== AW'(20 + k)) begin
        bad++;
        $display("FAIL rt_op%0d: got %0d want %0d", k, bus.out_rt_addr, 20 + k);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic          want_v;
    logic [AW-1:0] want_rt;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 3) drive(1'b1, 3'd0, rnd128(), rnd128(), '0, AW'(10 + c), 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 3'd0, '0, '0, '0, '0, (c == 4 || c == 5), 1'b0, 1'b0);
      tick();
      want_v  = (c >= 9 && c <= 11);
      want_rt = want_v ? AW'(c + 2) : '0;
      total++;
      if (bus.out_valid !== want_v || bus.out_rt_addr !== want_rt) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got v=%b rt=%0d want v=%b rt=%0d",
                 c, bus.out_valid, bus.out_rt_addr, want_v, want_rt);
      end
      obs  = {bus.out_valid, bus.out_rt_addr, bus.out_result, bus.busy};
      expv = {exp_valid, exp_rt, exp_res, exp_busy};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL b2b_model%0d: got %h want %h", c, obs, expv);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    logic [127:0] ra, rb, want;
    int n;
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 3'(c), rnd128(), rnd128(), 10'h2A, AW'(40 + c), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 3'd0, rnd128(), rnd128(), '0, AW'(44), 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: got busy=%b v=%b want 0 0", bus.busy, bus.out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL flush_quiet%0d: got v=%b busy=%b want 0 0", c, bus.out_valid, bus.busy);
      end
    end
    ra = rnd128();
    rb = rnd128();
    want = ref_vec(3'd4, ra, rb, '0);
    drive(1'b1, 3'd4, ra, rb, '0, AW'(55), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT || bus.out_result !== want || bus.out_rt_addr !== AW'(55)) begin
      bad++;
      $display("FAIL flush_reissue: got lat=%0d rt=%0d res=%h want lat=%0d rt=55 res=%h",
               n, bus.out_rt_addr, bus.out_result, LAT, want);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 2; c++) begin
      drive(1'b1, 3'd0, rnd128(), rnd128(), '0, AW'(60 + c), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 3'd0, rnd128(), rnd128(), '0, AW'(63), 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 12; c++) begin
      total++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_result !== '0) begin
        bad++;
        $display("FAIL reset_mid%0d: got v=%b busy=%b res=%h want 0", c,
                 bus.out_valid, bus.busy, bus.out_result);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400 + LAT + 2; c++) begin
      if (c < 400)
        drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd128(), rnd128(),
              10'($urandom), AW'($urandom), $urandom_range(0, 5) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
      else
        idle();
      tick();
      obs  = {bus.out_valid, bus.out_rt_addr, bus.out_result, bus.busy};
      expv = {exp_valid, exp_rt, exp_res, exp_busy};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL random_cycle%0d: got %h want %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
